// File: rtl/fifo_skew_feeder.sv
// fifo_skew_feeder: pops a programmed burst from one array-lane input FIFO
// and delays each word by SKEW cycles, so that the array edge sees a
// diagonal wavefront. After the burst it flushes the skew line and then
// pulses done.
//
// Handshake: a pop happens in exactly the cycle where fifo_r_enable=1. The
// word is taken from fifo_d_out in that same cycle. The downstream side has
// no ready signal. Instead, stall=1 freezes every register in the block.
// pe_valid qualifies pe_data, and pe_data is forced to 0 whenever pe_valid
// is 0.
module fifo_skew_feeder #(
  parameter int WORD_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int SKEW       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  stall,
  input  logic                  fifo_empty,
  input  logic                  fifo_w_enable,
  input  logic [WORD_WIDTH-1:0] fifo_d_out,
  output logic                  fifo_r_enable,
  output logic                  pe_valid,
  output logic [WORD_WIDTH-1:0] pe_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // With SKEW=0 DRAIN still lasts one cycle, so that the output register can
  // present the last word before done.
  localparam logic [6:0] DRAIN_LAST = 7'((SKEW == 0) ? 0 : SKEW - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH:0]    r_len;
  logic [LEN_WIDTH:0]    r_cnt;
  logic [LEN_WIDTH:0]    w_cnt_inc;
  logic [6:0]            r_drain_cnt;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_done;
  logic                  r_line_valid [0:SKEW];
  logic [WORD_WIDTH-1:0] r_line_data  [0:SKEW];

  assign w_cnt_inc = r_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};

  // Next-state logic, pop decision and done strobe.
  // The FIFO gives a write priority over a read, so no pop is issued in a
  // cycle where the FIFO is being written.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stall) begin
          w_accept    = 1'b1;
          w_state_nxt = (length == '0) ? S_DRAIN : S_FEED;
        end
      end
      S_FEED: begin
        w_pop = !stall && !fifo_empty && !fifo_w_enable && (r_cnt < r_len);
        if (w_pop && (w_cnt_inc == r_len)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!stall && (r_drain_cnt == DRAIN_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and burst counters. All of them hold while stall is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
    end else if (!stall) begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_len <= {1'b0, length};
        r_cnt <= '0;
      end else if (w_pop) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 7'd1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  // Skew shift line. Stage SKEW is the output register. Bubbles enter
  // whenever no word is popped, which keeps the lane at zero between bursts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i <= SKEW; i++) begin
        r_line_valid[i] <= 1'b0;
        r_line_data[i]  <= '0;
      end
    end else if (!stall) begin
      r_line_valid[0] <= w_pop;
      r_line_data[0]  <= w_pop ? fifo_d_out : '0;
      for (int i = 1; i <= SKEW; i++) begin
        r_line_valid[i] <= r_line_valid[i-1];
        r_line_data[i]  <= r_line_data[i-1];
      end
    end
  end

  // The pop strobe and done are gated by reset, so that a reset cycle
  // neither consumes a FIFO word nor reports completion.
  assign fifo_r_enable = w_pop && reset_n;
  assign done          = w_done && reset_n;
  assign busy          = (r_state != S_IDLE);
  assign pe_valid      = r_line_valid[SKEW];
  assign pe_data       = r_line_data[SKEW];
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fifo_skew_feeder.sv
// Bench for fifo_skew_feeder. Four lanes (SKEW = 0..3) share one stimulus
// bus. Only the selected lane sees start and a non-empty FIFO. A queue acts
// as the upstream FIFO. The reference model predicts every output from
// burst-level rules:
//   - a popped word shows up 1+SKEW live ticks later;
//   - done occurs 1+max(SKEW,1) live ticks after the last pop (or after
//     start when length is 0);
//   - busy stays high from start acceptance through done.
module tb_fifo_skew_feeder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] length;
  logic       stall;
  logic       fifo_empty;
  logic       fifo_w_enable;
  logic [7:0] fifo_d_out;
  logic [7:0] w_data;
  logic [1:0] sel;

  logic       ren_a  [4];
  logic       pv_a   [4];
  logic [7:0] pd_a   [4];
  logic       busy_a [4];
  logic       done_a [4];
  logic [1:0] dbg_a  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    fifo_skew_feeder #(.WORD_WIDTH(8), .LEN_WIDTH(8), .SKEW(g)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start && (sel == 2'(g))),
      .length        (length),
      .stall         (stall),
      .fifo_empty    (fifo_empty || (sel != 2'(g))),
      .fifo_w_enable (fifo_w_enable),
      .fifo_d_out    (fifo_d_out),
      .fifo_r_enable (ren_a[g]),
      .pe_valid      (pv_a[g]),
      .pe_data       (pd_a[g]),
      .busy          (busy_a[g]),
      .done          (done_a[g]),
      .dbg_state     (dbg_a[g])
    );
  end

  // scoreboard / model state
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         t_now;
  bit         m_busy;
  bit         m_done_known;
  int         m_done_tick;
  int         m_len;
  int         m_pops;
  bit         chk_on;
  logic       obs_ren;
  logic       obs_valid;
  logic       obs_done;
  int         n_cmp;
  int         n_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check at negedge, update the model at posedge, then
  // return #1 later so that new inputs never race the DUT.
  task automatic tick();
    logic       e_ren;
    logic       e_v;
    logic       e_done;
    logic [7:0] e_d;
    int         sk;
    int         dl;
    sk = int'(sel);
    dl = (sk > 0) ? sk : 1;
    fifo_empty = (fq.size() == 0);
    fifo_d_out = fifo_empty ? 8'h00 : fq[0];
    @(negedge clk);
    e_ren  = reset_n && m_busy && (m_pops < m_len) && !stall && !fifo_empty && !fifo_w_enable;
    e_v    = (exp_t.size() > 0) && (exp_t[0] == t_now);
    e_d    = e_v ? exp_q[0] : 8'h00;
    e_done = reset_n && m_busy && m_done_known && (t_now == m_done_tick) && !stall;
    if (chk_on) begin
      chk("fifo_r_enable", 32'(ren_a[sel]), 32'(e_ren));
      chk("pe_valid", 32'(pv_a[sel]), 32'(e_v));
      chk("pe_data", 32'(pd_a[sel]), 32'(e_d));
      chk("busy", 32'(busy_a[sel]), 32'(m_busy));
      chk("done", 32'(done_a[sel]), 32'(e_done));
    end
    obs_ren   = ren_a[sel];
    obs_valid = pv_a[sel];
    obs_done  = done_a[sel];
    @(posedge clk);
    if (!reset_n) begin
      m_busy       = 1'b0;
      m_done_known = 1'b0;
      exp_t.delete();
      exp_q.delete();
    end else if (!stall) begin
      if (e_ren) begin
        exp_t.push_back(t_now + 1 + sk);
        exp_q.push_back(fq[0]);
        m_pops++;
        if (m_pops == m_len) begin
          m_done_known = 1'b1;
          m_done_tick  = t_now + 1 + dl;
        end
      end
      if (m_busy && m_done_known && (t_now == m_done_tick)) begin
        m_busy = 1'b0;
      end else if (!m_busy && start) begin
        m_busy = 1'b1;
        m_len  = int'(length);
        m_pops = 0;
        m_done_known = (length == 8'd0);
        m_done_tick  = t_now + 1 + dl;
      end
      if ((exp_t.size() > 0) && (exp_t[0] == t_now)) begin
        void'(exp_t.pop_front());
        void'(exp_q.pop_front());
      end
      t_now++;
    end
    if (obs_ren && (fq.size() > 0)) void'(fq.pop_front());
    if (fifo_w_enable) fq.push_back(w_data);
    #1;
  endtask

  // stall_at: -1 = no stall, -2 = random stall, else stall for stall_n walls
  // wr_every: 0 = random write timing, else write every wr_every walls
  task automatic run_burst(input int lane, input int len, input int n_wr, input int wr_every,
                           input int stall_at, input int stall_n, input int restart_at,
                           input int rst_at, input int exp_done_wall);
    int wall;
    int wr_left;
    int n_valid;
    int n_done;
    int done_wall;
    wr_left   = n_wr;
    n_valid   = 0;
    n_done    = 0;
    done_wall = -1;
    sel    = 2'(lane);
    start  = 1'b1;
    length = 8'(len);
    stall  = 1'b0;
    fifo_w_enable = 1'b0;
    tick();
    start = 1'b0;
    wall  = 1;
    while (m_busy && (wall < 2000)) begin
      if (stall_at == -2) stall = ($urandom_range(0, 4) == 0);
      else stall = (stall_at >= 0) && (wall >= stall_at) && (wall < stall_at + stall_n);
      fifo_w_enable = (wr_left > 0) &&
                      ((wr_every > 0) ? (wall % wr_every == 0) : ($urandom_range(0, 2) == 0));
      if (fifo_w_enable) begin
        wr_left--;
        w_data = 8'($urandom);
      end
      start   = (wall == restart_at);
      length  = 8'd9;
      reset_n = (wall != rst_at);
      tick();
      if (!stall && obs_valid) n_valid++;
      if (obs_done) begin
        n_done++;
        done_wall = wall;
      end
      wall++;
    end
    stall = 1'b0;
    start = 1'b0;
    fifo_w_enable = 1'b0;
    reset_n = 1'b1;
    chk("timeout", 32'(m_busy), 32'd0);
    if (rst_at < 0) begin
      chk("valid_words", 32'(n_valid), 32'(len));
      chk("done_pulses", 32'(n_done), 32'd1);
      if (exp_done_wall >= 0) chk("done_wall", 32'(done_wall), 32'(exp_done_wall));
    end else begin
      chk("no_done_after_reset", 32'(n_done), 32'd0);
    end
    tick();
    tick();
  endtask

  initial begin
    int len;
    int pre;
    n_cmp = 0; n_mis = 0; t_now = 0; chk_on = 1'b0;
    m_busy = 1'b0; m_done_known = 1'b0; m_done_tick = 0; m_len = 0; m_pops = 0;
    sel = 2'd0; start = 1'b0; length = 8'd0; stall = 1'b0;
    fifo_w_enable = 1'b0; w_data = 8'h00; reset_n = 1'b0;
    // reset: the first cycle has unknown register contents, then check the cleared state
    tick();
    chk_on = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // SKEW=0, three preloaded words, plus a second start while busy
    fq = '{8'h11, 8'h22, 8'h33};
    run_burst(0, 3, 0, 1, -1, 0, 2, -1, 5);

    // SKEW=3, same words: done 1+3+3 ticks after start
    fq = '{8'h11, 8'h22, 8'h33};
    run_burst(3, 3, 0, 1, -1, 0, -1, -1, 7);

    // SKEW=2, one word preloaded and three more written every 3 cycles
    fq = '{8'hA5};
    run_burst(2, 4, 3, 3, -1, 0, -1, -1, -1);

    // writes while the FIFO is non-empty in FEED suppress the pop
    fq = '{8'h01, 8'h02};
    run_burst(0, 4, 2, 1, -1, 0, -1, -1, -1);

    // SKEW=1, 5-cycle stall mid-FEED delays done by exactly 5
    fq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    run_burst(1, 6, 0, 1, 3, 5, -1, -1, 13);

    // length 0
    fq.delete();
    run_burst(2, 0, 0, 1, -1, 0, -1, -1, 3);
    run_burst(0, 0, 0, 1, -1, 0, -1, -1, 2);

    // reset mid-FEED: no done, and the FIFO keeps its unpopped words
    fq = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    run_burst(3, 5, 0, 1, -1, 0, -1, 3, -1);
    chk("fifo_left_after_reset", 32'(fq.size()), 32'd3);
    fq.delete();

    // maximum length: the counter must not wrap
    for (int i = 0; i < 255; i++) fq.push_back(8'(i));
    run_burst(1, 255, 0, 1, -1, 0, -1, -1, 257);

    // randomized bursts with random stalls and write interference
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(1, 10);
      pre = $urandom_range(0, len);
      fq.delete();
      for (int i = 0; i < pre; i++) fq.push_back(8'($urandom));
      run_burst($urandom_range(0, 3), len, len - pre, 0, -2, 0, $urandom_range(1, 6), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
